slow_to_fast_bridge: RTL

- Return path for the divided-clock pipeline. Samples a word produced at the slow-stage rate and buffers it in a small FIFO. Hands it back to fast-domain logic over a valid/ready handshake.
- Uses one clock only. The slow rate is an internal enable pulse (slow_tick) derived from fast_clk by a modulo-DIV counter; there is no second clock net.
- Sits downstream of the stage-2 result, feeding fast-rate consumers.

---
 rtl/slow_to_fast_bridge.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/slow_to_fast_bridge.sv
// slow_to_fast_bridge
//   Return path for the divided-clock pipeline. A modulo-DIV counter on
//   fast_clk produces a one-cycle capture strobe (slow_tick). Words offered on
//   in_data/in_valid are sampled only on tick cycles and queued in a DEPTH-entry
//   FIFO. The FIFO drains to fast-rate consumers over out_valid/out_ready.
//
// Parameters
//   DATA_W : data path width
//   DIV    : fast_clk cycles per slow period (even, >= 2)
//   DEPTH  : FIFO entries (power of 2, >= 2)
//
// Ports
//   fast_clk  in   sole clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_data   in   slow-rate input word
//   in_valid  in   in_data valid, sampled on slow_tick cycles only
//   slow_clk  out  registered divided-clock phase (observability only)
//   slow_tick out  one-cycle capture strobe, every DIV cycles
//   out_data  out  FIFO head word, 0 when empty
//   out_valid out  FIFO non-empty
//   out_ready in   consumer accepts the head word
//   full      out  count == DEPTH
//   empty     out  count == 0
//   count     out  occupancy
//   overflow  out  sticky: a word was dropped
//   ovf_clr   in   clears overflow (and seq_err when enabled)
//   seq_err   out  only with SLOW_BRIDGE_SEQ_CHECK_EN defined: sticky flag set
//                  when an accepted word is not the previous accepted word + 1
//
// Optional feature macro: SLOW_BRIDGE_SEQ_CHECK_EN
module slow_to_fast_bridge #(
  parameter int DATA_W = 8,
  parameter int DIV    = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       fast_clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       slow_clk,
  output logic                       slow_tick,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  input  logic                       ovf_clr
`ifdef SLOW_BRIDGE_SEQ_CHECK_EN
  ,
  output logic                       seq_err
`endif
);

  localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;

  // ---------------------------------------------------------------------------
  // Divider
  // ---------------------------------------------------------------------------
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_slow_clk;
  logic          r_slow_tick;

  always_comb begin
    w_cnt_nxt = (r_cnt == CW'(DIV - 1)) ? '0 : r_cnt + CW'(1);
  end

  // Phase and tick are registered from the next count so they stay aligned
  // with r_cnt: tick is high exactly while r_cnt == DIV-1.
  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_slow_clk  <= 1'b0;
      r_slow_tick <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_slow_clk  <= (w_cnt_nxt >= CW'(DIV / 2));
      r_slow_tick <= (w_cnt_nxt == CW'(DIV - 1));
    end
  end

  assign slow_clk  = r_slow_clk;
  assign slow_tick = r_slow_tick;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CNTW-1:0]   r_count;
  logic              r_overflow;

  logic w_full;
  logic w_empty;
  logic w_push_req;
  logic w_pop;
  logic w_push;
  logic w_drop;

  always_comb begin
    w_full     = (r_count == CNTW'(DEPTH));
    w_empty    = (r_count == '0);
    w_pop      = !w_empty && out_ready;
    w_push_req = r_slow_tick && in_valid;
    // A full FIFO still accepts when the head leaves on the same edge.
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
  end

  // Storage is deliberately not reset; pointers/count define validity.
  always_ff @(posedge fast_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign out_valid = !w_empty;
  assign full      = w_full;
  assign empty     = w_empty;
  assign count     = r_count;
  assign overflow  = r_overflow;

`ifdef SLOW_BRIDGE_SEQ_CHECK_EN
  // ---------------------------------------------------------------------------
  // Sequence checker: each accepted word must be the previous accepted word + 1.
  // Dropped words never reach w_push, so they leave the reference untouched.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_last;
  logic              r_have_ref;
  logic              r_seq_err;
  logic              w_seq_mismatch;

  always_comb begin
    w_seq_mismatch = w_push && r_have_ref && (in_data != (r_last + DATA_W'(1)));
  end

  always_ff @(posedge fast_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last     <= '0;
      r_have_ref <= 1'b0;
      r_seq_err  <= 1'b0;
    end else begin
      if (w_push) begin
        r_last     <= in_data;
        r_have_ref <= 1'b1;
      end
      if (w_seq_mismatch) begin
        r_seq_err <= 1'b1;
      end else if (ovf_clr) begin
        r_seq_err <= 1'b0;
      end
    end
  end

  assign seq_err = r_seq_err;
`endif

endmodule
